// File: rtl/count_sequencer.sv
// count_sequencer: queues count-limit commands in a small FIFO and issues them
// one at a time to an attached 0..limit counter, watching its busy flag to
// detect run completion or a failure to start.
module count_sequencer #(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [16:0] cmd_limit,
  output logic        cmd_ready,
  output logic        cnt_start,
  output logic [16:0] cnt_limit,
  input  logic        cnt_counting,
  output logic        done,
  output logic [16:0] done_limit,
  output logic        timeout_err,
  output logic        busy,
  output logic [15:0] runs_done,
  output logic [4:0]  fifo_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RISE = 2'd2;
  localparam logic [1:0] ST_WAIT_FALL = 2'd3;

  localparam logic [4:0] LEVEL_FULL = 5'(DEPTH);
  localparam logic [3:0] TMO_LAST   = 4'(START_TIMEOUT - 1);

  logic [16:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic          cnt_start_q, cnt_start_d;
  logic [16:0]   cnt_limit_q, cnt_limit_d;
  logic          done_q, done_d;
  logic [16:0]   done_limit_q, done_limit_d;
  logic          tmo_err_q, tmo_err_d;
  logic [15:0]   runs_q, runs_d;
  logic [3:0]    tmo_cnt_q, tmo_cnt_d;
  logic          push;
  logic          pop;

  assign cmd_ready   = (level_q != LEVEL_FULL);
  assign cnt_start   = cnt_start_q;
  assign cnt_limit   = cnt_limit_q;
  assign done        = done_q;
  assign done_limit  = done_limit_q;
  assign timeout_err = tmo_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign runs_done   = runs_q;
  assign fifo_level  = level_q;

  // FIFO bookkeeping; a pop is held off during the done cycle so the next
  // start pulse lands at least two cycles after done.
  always_comb begin
    push     = cmd_valid && cmd_ready;
    pop      = (state_q == ST_IDLE) && (level_q != 5'd0) && !done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + 5'd1;
    end else if (!push && pop) begin
      level_d = level_q - 5'd1;
    end
  end

  // Run sequencer: issue, wait for the counter to rise, then wait for it to fall.
  always_comb begin
    state_d      = state_q;
    cnt_start_d  = 1'b0;
    cnt_limit_d  = cnt_limit_q;
    done_d       = 1'b0;
    done_limit_d = done_limit_q;
    tmo_err_d    = tmo_err_q;
    runs_d       = runs_q;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d     = ST_ISSUE;
          cnt_limit_d = mem_q[rd_ptr_q];
          cnt_start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT_RISE;
        tmo_cnt_d = 4'd0;
      end
      ST_WAIT_RISE: begin
        if (cnt_counting) begin
          state_d = ST_WAIT_FALL;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
      end
      ST_WAIT_FALL: begin
        if (!cnt_counting) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          done_limit_d = cnt_limit_q;
          runs_d       = runs_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command storage; contents need no reset because the level gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_limit;
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= 5'd0;
      state_q      <= ST_IDLE;
      cnt_start_q  <= 1'b0;
      cnt_limit_q  <= 17'd0;
      done_q       <= 1'b0;
      done_limit_q <= 17'd0;
      tmo_err_q    <= 1'b0;
      runs_q       <= 16'd0;
      tmo_cnt_q    <= 4'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      state_q      <= state_d;
      cnt_start_q  <= cnt_start_d;
      cnt_limit_q  <= cnt_limit_d;
      done_q       <= done_d;
      done_limit_q <= done_limit_d;
      tmo_err_q    <= tmo_err_d;
      runs_q       <= runs_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule
